// File: rtl/fpu_pkg.sv
// Shared single-precision field widths, class bit positions and FIFO entry layout.
// The entry layout is {class, {overflow, underflow}, result}; class is absent when classification is disabled.
package fpu_pkg;

  localparam int SP_W     = 32;
  localparam int SP_EXP_W = 8;
  localparam int SP_MAN_W = 23;
  localparam logic [SP_EXP_W-1:0] SP_EXP_MAX = 8'hFF;

  localparam int CLASS_W      = 4;
  localparam int CLASS_NAN    = 3;
  localparam int CLASS_INF    = 2;
  localparam int CLASS_ZERO   = 1;
  localparam int CLASS_DENORM = 0;

  localparam int FLAGS_W = 2;
  localparam int ENTRY_W = CLASS_W + FLAGS_W + SP_W;

  function automatic logic [CLASS_W-1:0] sp_classify(input logic [SP_EXP_W-1:0] exp,
                                                     input logic [SP_MAN_W-1:0] man);
    logic [CLASS_W-1:0] cls;
    logic               man_nz;
    man_nz              = |man;
    cls                 = '0;
    cls[CLASS_NAN]      = (exp == SP_EXP_MAX) &&  man_nz;
    cls[CLASS_INF]      = (exp == SP_EXP_MAX) && !man_nz;
    cls[CLASS_ZERO]     = (exp == '0)         && !man_nz;
    cls[CLASS_DENORM]   = (exp == '0)         &&  man_nz;
    return cls;
  endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// In-order synchronous FIFO with occupancy counter; pushes when full and pops when empty are dropped.
// Data is visible on dout_o the cycle after the push; dout_o reads zero while empty.
module fpu_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (occ_q == OCC_W'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointers are exactly log2(DEPTH) wide, so they wrap to 0 without explicit logic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fpu_sp_result_stage.sv
// Adder output stage: FIFO of {result, flags}, sticky flags and saturating result count; one-cycle latency, in_ready = !full.
// Define FPU_CLASSIFY_EN to store a {nan, inf, zero, denorm} class with each entry; otherwise out_class is 0.
module fpu_sp_result_stage
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SP_W-1:0]    in_result,
  input  logic               in_overflow,
  input  logic               in_underflow,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SP_W-1:0]    out_result,
  output logic [FLAGS_W-1:0] out_flags,
  output logic [CLASS_W-1:0] out_class,
  input  logic               status_clr,
  output logic               sticky_ovf,
  output logic               sticky_unf,
  output logic [CNT_W-1:0]   result_count
);

`ifdef FPU_CLASSIFY_EN
  localparam int FIFO_W = ENTRY_W;
`else
  localparam int FIFO_W = ENTRY_W - CLASS_W;
`endif

  logic              full, empty, push, pop;
  logic [FIFO_W-1:0] fifo_din, fifo_dout;
  logic              sticky_ovf_q, sticky_ovf_d;
  logic              sticky_unf_q, sticky_unf_d;
  logic [CNT_W-1:0]  count_q, count_d, count_base;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef FPU_CLASSIFY_EN
  assign fifo_din  = {sp_classify(in_result[SP_W-2 -: SP_EXP_W], in_result[SP_MAN_W-1:0]),
                      in_overflow, in_underflow, in_result};
  assign out_class = fifo_dout[FIFO_W-1 -: CLASS_W];
`else
  assign fifo_din  = {in_overflow, in_underflow, in_result};
  assign out_class = '0;
`endif

  assign out_result = fifo_dout[SP_W-1:0];
  assign out_flags  = fifo_dout[SP_W +: FLAGS_W];

  fpu_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .full_o  (full),
    .empty_o (empty),
    .dout_o  (fifo_dout)
  );

  // Clear is applied before the same-cycle push so a simultaneous set survives.
  always_comb begin
    sticky_ovf_d = status_clr ? 1'b0 : sticky_ovf_q;
    sticky_unf_d = status_clr ? 1'b0 : sticky_unf_q;
    count_base   = status_clr ? '0 : count_q;
    count_d      = count_base;
    if (push) begin
      sticky_ovf_d = sticky_ovf_d | in_overflow;
      sticky_unf_d = sticky_unf_d | in_underflow;
      if (count_base != '1) count_d = count_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
      count_q      <= '0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
      count_q      <= count_d;
    end
  end

  assign sticky_ovf   = sticky_ovf_q;
  assign sticky_unf   = sticky_unf_q;
  assign result_count = count_q;

endmodule

// File: tb/tb_fpu_sp_result_stage.sv
// Scoreboard bench for fpu_sp_result_stage: a reference model tracks queue, sticky flags and count every cycle.
// A second instance with a 2-bit counter exercises count saturation.
module tb_fpu_sp_result_stage;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [31:0] res;
    logic [1:0]  flg;
    logic [3:0]  cls;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_overflow = 1'b0, in_underflow = 1'b0;
  logic [31:0] in_result = '0;
  logic        out_ready = 1'b0, status_clr = 1'b0;
  logic        in_ready, out_valid, sticky_ovf, sticky_unf;
  logic [31:0] out_result;
  logic [1:0]  out_flags;
  logic [3:0]  out_class;
  logic [CNT_W-1:0] result_count;

  logic        in_valid2 = 1'b0;
  logic        in_ready2, out_valid2, sticky_ovf2, sticky_unf2;
  logic [31:0] out_result2;
  logic [1:0]  out_flags2;
  logic [3:0]  out_class2;
  logic [1:0]  result_count2;

  exp_t        sb[$];
  logic        m_ovf = 1'b0, m_unf = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic        mon_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  fpu_sp_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_overflow(in_overflow), .in_underflow(in_underflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_class(out_class),
    .status_clr(status_clr), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf),
    .result_count(result_count)
  );

  fpu_sp_result_stage #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_result(32'h3F800000),
    .in_overflow(1'b0), .in_underflow(1'b0),
    .out_valid(out_valid2), .out_ready(1'b1), .out_result(out_result2),
    .out_flags(out_flags2), .out_class(out_class2),
    .status_clr(1'b0), .sticky_ovf(sticky_ovf2), .sticky_unf(sticky_unf2),
    .result_count(result_count2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [3:0] ref_class(input logic [31:0] v);
    logic [3:0] c;
    c = 4'b0000;
`ifdef FPU_CLASSIFY_EN
    if (v[30:23] == 8'hFF) c = (v[22:0] != 0) ? 4'b1000 : 4'b0100;
    else if (v[30:23] == 8'h00) c = (v[22:0] != 0) ? 4'b0001 : 4'b0010;
`endif
    return c;
  endfunction

  // Reference model: checks current state, then advances with this cycle's handshakes.
  always @(negedge clk) begin
    logic m_push, m_pop;
    exp_t e;
    if (mon_en) begin
      check("in_ready", in_ready, sb.size() < DEPTH);
      check("out_valid", out_valid, sb.size() != 0);
      check("occupancy", sb.size() <= DEPTH, 1);
      check("sticky_ovf", sticky_ovf, m_ovf);
      check("sticky_unf", sticky_unf, m_unf);
      check("result_count", result_count, m_cnt);
      if (sb.size() == 0) begin
        check("empty_result", out_result, 0);
        check("empty_flags", out_flags, 0);
        check("empty_class", out_class, 0);
      end
    end
    if (!rst_n) begin
      sb.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_cnt = '0;
    end else begin
      m_push = in_valid && (sb.size() < DEPTH);
      m_pop  = out_ready && (sb.size() != 0);
      if (m_pop) begin
        e = sb.pop_front();
        if (mon_en) begin
          check("out_result", out_result, e.res);
          check("out_flags", out_flags, e.flg);
          check("out_class", out_class, e.cls);
        end
      end
      if (status_clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_cnt = '0;
      end
      if (m_push) begin
        sb.push_back('{res: in_result, flg: {in_overflow, in_underflow}, cls: ref_class(in_result)});
        m_ovf = m_ovf | in_overflow;
        m_unf = m_unf | in_underflow;
        if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic push(input logic [31:0] r, input logic ov, input logic un, input logic tog);
    int  n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_result = r;
    in_overflow = ov;
    in_underflow = un;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (tog) out_ready = ~out_ready;
      n++;
    end
    in_valid = 1'b0;
    in_overflow = 1'b0;
    in_underflow = 1'b0;
    if (!acc) check("push_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    // Reset with in_valid asserted: nothing may be stored.
    in_valid = 1'b1;
    in_result = 32'h12345678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", result_count, 0);
    check("rst_sticky_ovf", sticky_ovf, 0);
    check("rst_sticky_unf", sticky_unf, 0);
    check("rst_out_result", out_result, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single pass
    out_ready = 1'b1;
    push(32'h40400000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("single_valid", out_valid, 1);
    check("single_result", out_result, 32'h40400000);
    check("single_count", result_count, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("single_empty", out_valid, 0);
    @(posedge clk);
    #1;

    // Full and backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h41000000 + i, i[0], i[1], 1'b0);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_head", out_result, 32'h41000000);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_result = 32'h41000004;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(32'h41000004, 1'b0, 1'b0, 1'b0);
    drain();
    check("full_count", result_count, 6);

    // Stream across pointer wrap with toggling consumer
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) push(32'h42000000 + (i * 3), 1'b0, 1'b0, 1'b1);
    drain();

    // Sticky flags and clear-with-push
    push(32'h7F7FFFFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("sticky_set_ovf", sticky_ovf, 1);
    @(posedge clk);
    #1;
    status_clr = 1'b1;
    push(32'h00800000, 1'b0, 1'b1, 1'b0);
    status_clr = 1'b0;
    @(negedge clk);
    check("clr_push_ovf", sticky_ovf, 0);
    check("clr_push_unf", sticky_unf, 1);
    check("clr_push_count", result_count, 1);
    @(posedge clk);
    #1;
    drain();

    // Classification (all zero without the classifier)
    out_ready = 1'b0;
    push(32'h7FC00000, 1'b0, 1'b0, 1'b0);
    push(32'h7F800000, 1'b0, 1'b0, 1'b0);
    push(32'h00000000, 1'b0, 1'b0, 1'b0);
    push(32'h00000001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
`ifdef FPU_CLASSIFY_EN
    check("class_nan_head", out_class, 4'b1000);
`else
    check("class_off_head", out_class, 4'b0000);
`endif
    @(posedge clk);
    #1;
    drain();

    // Reset mid-transfer discards entries
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h43000000 + i, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    check("midrst_count", result_count, 0);
    check("midrst_ovf", sticky_ovf, 0);
    @(posedge clk);
    #1;

    // Saturating 2-bit counter on the second instance
    in_valid2 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("sat_count", result_count2, (i < 3) ? i : 3);
      check("sat_ready", in_ready2, 1);
      check("sat_valid", out_valid2, 1);
      check("sat_result", out_result2, 32'h3F800000);
      check("sat_flags", {out_flags2, sticky_ovf2, sticky_unf2, out_class2}, 0);
    end
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
